// File: rtl/cordic_rr_scheduler_pkg.sv
// Shared constants, angle fold and saturating negate for the
// CORDIC round-robin scheduler.
package cordic_pkg;

    localparam int WIDTH   = 16;
    localparam int ANGLE_W = 32;

    localparam logic signed [WIDTH-1:0] XIN_INIT  = 16'sd19429;
    localparam logic [ANGLE_W-1:0]      ANGLE_90  = 32'h4000_0000;
    localparam logic [ANGLE_W-1:0]      ANGLE_180 = 32'h8000_0000;

    localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};

    typedef struct packed {
        logic [ANGLE_W-1:0] angle;
        logic               neg;
    } fold_t;

    // Angles in the left half-plane are rotated by 180 deg; the result is negated later.
    function automatic fold_t fold(input logic [ANGLE_W-1:0] a);
        fold_t f;
        f.neg   = (a >= ANGLE_90) && (a < ANGLE_180 + ANGLE_90);
        f.angle = f.neg ? a - ANGLE_180 : a;
        return f;
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_neg(
        input logic signed [WIDTH-1:0] x
    );
        if (x == S_MIN) begin
            return S_MAX;
        end
        return -x;
    endfunction

endpackage

// File: rtl/cordic_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after
// the pointer; the pointer moves to the grantee on advance.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        grant = '0;
        win   = ptr;
        cand  = ptr;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        if (found && !rst) begin
            grant[win] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= LAST;
        end else if (advance && found) begin
            ptr <= win;
        end
    end

endmodule

// File: rtl/cordic_rr_scheduler.sv
// Shares one pipelined CORDIC among NUM_REQ requesters: arbitrate,
// fold, track issues with a tag pipe and route results back.
import cordic_pkg::*;

module cordic_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int LAT     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ANGLE_W-1:0]  req_angle,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic signed [WIDTH-1:0]     rsp_cos,
    output logic signed [WIDTH-1:0]     rsp_sin,
    output logic                        busy,
    output logic signed [WIDTH-1:0]     cordic_xin,
    output logic signed [WIDTH-1:0]     cordic_yin,
    output logic [ANGLE_W-1:0]          cordic_angle,
    input  logic signed [WIDTH-1:0]     cordic_cos,
    input  logic signed [WIDTH-1:0]     cordic_sin
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
        logic           neg;
    } tag_t;

    logic [NUM_REQ-1:0] grant;
    logic               take;
    logic [ANGLE_W-1:0] sel_angle;
    logic [IDW-1:0]     sel_id;
    fold_t              fa;
    tag_t               launch;
    tag_t               pipe [LAT];
    tag_t               exit_tag;
    logic               pipe_busy;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (take),
        .grant   (grant)
    );

    assign req_ready  = grant;
    assign take       = |(req_valid & grant);
    assign cordic_xin = XIN_INIT;
    assign cordic_yin = '0;

    always_comb begin
        sel_angle = '0;
        sel_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_angle = req_angle[i*ANGLE_W +: ANGLE_W];
                sel_id    = IDW'(i);
            end
        end
    end

    assign fa = fold(sel_angle);

    // The launch tag travels with cordic_angle; the CORDIC samples it one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            cordic_angle <= '0;
            launch       <= '0;
        end else begin
            launch.vld <= take;
            launch.id  <= sel_id;
            launch.neg <= take & fa.neg;
            if (take) begin
                cordic_angle <= fa.angle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            pipe[0] <= launch;
            for (int k = 1; k < LAT; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    assign exit_tag = pipe[LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_cos   <= '0;
            rsp_sin   <= '0;
        end else begin
            rsp_valid <= exit_tag.vld ? (NUM_REQ'(1) << exit_tag.id) : '0;
            if (exit_tag.vld) begin
                rsp_cos <= exit_tag.neg ? sat_neg(cordic_cos) : cordic_cos;
                rsp_sin <= exit_tag.neg ? sat_neg(cordic_sin) : cordic_sin;
            end
        end
    end

    always_comb begin
        pipe_busy = launch.vld;
        for (int k = 0; k < LAT; k++) begin
            pipe_busy = pipe_busy | pipe[k].vld;
        end
    end

    assign busy = pipe_busy | (|rsp_valid);

endmodule
